// File: rtl/updown_counter_mod_pkg.sv
// Shared types for the up/down counter: count mode encoding and the event
// code passed from the next-state datapath to the flag logic.
package updown_counter_mod_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_OVF  = 2'd1,
    EVT_UNF  = 2'd2
  } evt_e;

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control and status bundle of the up/down counter. The master drives the
// controls; the slave (the counter) drives the count and flags.
interface updown_counter_mod_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              en;
  logic              load;
  logic              up_down;
  logic              mode;
  logic [WIDTH-1:0]  in;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic              flag_clr;
  logic [WIDTH-1:0]  out;
  logic              at_max;
  logic              at_zero;
  logic              wrap_p;
  logic              ovf;
  logic              unf;

  modport master (
    output en, load, up_down, mode, in, step, limit, flag_clr,
    input  out, at_max, at_zero, wrap_p, ovf, unf
  );

  modport slave (
    input  en, load, up_down, mode, in, step, limit, flag_clr,
    output out, at_max, at_zero, wrap_p, ovf, unf
  );
endinterface

// File: rtl/updown_counter_next.sv
// Combinational next-count datapath: one step up or down within 0..limit,
// wrapping or saturating, and reporting which boundary was crossed.
module updown_counter_next
  import updown_counter_mod_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  out,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              up_down,
  input  logic              mode,
  output logic [WIDTH-1:0]  nxt,
  output evt_e              evt
);

  // One extra bit so limit+1 and out+step never overflow.
  logic [WIDTH:0] cur, stp, lim, lim1, sum;

  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    cur  = {1'b0, out};
    stp  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    lim  = {1'b0, limit};
    lim1 = lim + 1'b1;
    sum  = cur + stp;
    nxt  = out;
    evt  = EVT_NONE;

    if (stp == '0) begin
      nxt = out;
    end else if (cur > lim) begin
      // Limit was lowered below the current count: pull back into range.
      nxt = limit;
      evt = EVT_OVF;
    end else if (up_down) begin
      if (sum <= lim) begin
        nxt = WIDTH'(sum);
      end else begin
        evt = EVT_OVF;
        if (mode == MODE_SAT)  nxt = limit;
        else if (stp > lim1)   nxt = '0;
        else                   nxt = WIDTH'(sum - lim1);
      end
    end else begin
      if (stp <= cur) begin
        nxt = WIDTH'(cur - stp);
      end else begin
        evt = EVT_UNF;
        if (mode == MODE_SAT)  nxt = '0;
        else if (stp > lim1)   nxt = '0;
        else                   nxt = WIDTH'(cur + lim1 - stp);
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised load/up-down counter with run-time limit, wrap or saturate
// mode, sticky overflow/underflow flags and a one-cycle boundary pulse.
module updown_counter_mod
  import updown_counter_mod_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 4,
  parameter int RST_VAL = 0
) (
  input  logic                  clk,
  input  logic                  clear,
  updown_counter_mod_if.slave   bus
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ld_val;
  evt_e             evt;
  evt_e             evt_now;
  logic             wrap_p_q;
  logic             ovf_q;
  logic             unf_q;

  updown_counter_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .out     (cnt),
    .step    (bus.step),
    .limit   (bus.limit),
    .up_down (bus.up_down),
    .mode    (bus.mode),
    .nxt     (nxt),
    .evt     (evt)
  );

  assign ld_val  = (bus.in > bus.limit) ? bus.limit : bus.in;
  // Load overrides counting, so its cycle can never raise an event.
  assign evt_now = (bus.en && !bus.load) ? evt : EVT_NONE;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!clear) begin
      cnt      <= WIDTH'(RST_VAL);
      wrap_p_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (bus.load)    cnt <= ld_val;
      else if (bus.en) cnt <= nxt;
      wrap_p_q <= (evt_now != EVT_NONE);
      // A new event beats a simultaneous flag_clr.
      ovf_q    <= (evt_now == EVT_OVF) || (ovf_q && !bus.flag_clr);
      unf_q    <= (evt_now == EVT_UNF) || (unf_q && !bus.flag_clr);
    end
  end

  assign bus.out     = cnt;
  assign bus.at_max  = (cnt == bus.limit);
  assign bus.at_zero = (cnt == '0);
  assign bus.wrap_p  = wrap_p_q;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod: directed vectors push expected
// results; a monitor pops and compares after every clock edge.
module tb_updown_counter_mod;

  localparam logic UP = 1'b1, DN = 1'b0, WR = 1'b0, SA = 1'b1;

  typedef struct {
    logic [7:0] out;
    logic [4:0] flags;  // {wrap_p, ovf, unf, at_max, at_zero}
  } exp_t;

  logic clk;
  logic clear;
  int   total;
  int   bad;
  exp_t sb_q[$];

  updown_counter_mod_if #(.WIDTH(8), .STEP_W(4)) bus ();

  updown_counter_mod #(
    .WIDTH   (8),
    .STEP_W  (4),
    .RST_VAL (0)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the state expected after the edge.
  task automatic cyc(input logic cl, input logic ld, input logic en,
                     input logic ud, input logic md, input logic [7:0] inv,
                     input logic [3:0] st, input logic [7:0] lim, input logic fc,
                     input logic [7:0] eo, input logic ewp, input logic eovf,
                     input logic eunf);
    exp_t e;
    @(negedge clk);
    clear        = cl;
    bus.load     = ld;
    bus.en       = en;
    bus.up_down  = ud;
    bus.mode     = md;
    bus.in       = inv;
    bus.step     = st;
    bus.limit    = lim;
    bus.flag_clr = fc;
    e.out   = eo;
    e.flags = {ewp, eovf, eunf, (eo == lim), (eo == 8'd0)};
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out", 32'(bus.out), 32'(e.out));
        check("flags", 32'({bus.wrap_p, bus.ovf, bus.unf, bus.at_max, bus.at_zero}),
              32'(e.flags));
      end
    end
  end

  initial begin : stim
    total = 0;
    bad   = 0;
    clear = 1'b0;
    bus.load = 1'b0; bus.en = 1'b0; bus.up_down = 1'b0; bus.mode = 1'b0;
    bus.in = '0; bus.step = '0; bus.limit = 8'd9; bus.flag_clr = 1'b0;

    //   cl ld en ud  md  in   st  lim  fc  out  wp ovf unf
    cyc(0, 0, 0, UP, WR, 0,   0,  9,   0,  0,   0, 0, 0);
    // Wrap up by one through limit 9.
    for (int i = 1; i <= 9; i++)
      cyc(1, 0, 1, UP, WR, 0, 1, 9, 0, 8'(i), 0, 0, 0);
    cyc(1, 0, 1, UP, WR, 0,   1,  9,   0,  0,   1, 1, 0);
    cyc(1, 0, 1, UP, WR, 0,   1,  9,   0,  1,   0, 1, 0);
    cyc(1, 0, 1, UP, WR, 0,   1,  9,   0,  2,   0, 1, 0);
    // Saturate up by four.
    cyc(0, 0, 0, UP, SA, 0,   0,  9,   0,  0,   0, 0, 0);
    cyc(1, 0, 1, UP, SA, 0,   4,  9,   0,  4,   0, 0, 0);
    cyc(1, 0, 1, UP, SA, 0,   4,  9,   0,  8,   0, 0, 0);
    cyc(1, 0, 1, UP, SA, 0,   4,  9,   0,  9,   1, 1, 0);
    cyc(1, 0, 1, UP, SA, 0,   4,  9,   0,  9,   1, 1, 0);
    // Wrap down across zero with limit 200, then clear the flag alone.
    cyc(0, 0, 0, DN, WR, 0,   0, 200,  0,  0,   0, 0, 0);
    cyc(1, 1, 0, DN, WR, 1,   0, 200,  0,  1,   0, 0, 0);
    cyc(1, 0, 1, DN, WR, 0,   3, 200,  0, 199,  1, 0, 1);
    cyc(1, 0, 0, DN, WR, 0,   3, 200,  1, 199,  0, 0, 0);
    // Load clamps to limit; load beats a simultaneous count.
    cyc(1, 1, 0, UP, WR, 250, 0, 100,  0, 100,  0, 0, 0);
    cyc(1, 1, 1, UP, WR, 250, 5, 100,  0, 100,  0, 0, 0);
    // Limit lowered below count, then reset mid-count.
    cyc(1, 1, 0, DN, WR, 50,  0, 100,  0, 50,   0, 0, 0);
    cyc(1, 0, 1, DN, WR, 0,   1,  20,  0, 20,   1, 1, 0);
    cyc(0, 0, 1, DN, WR, 0,   1,  20,  0,  0,   0, 0, 0);
    // Event wins over flag_clr; step 0 holds; flag_clr alone clears.
    cyc(1, 1, 0, UP, WR, 8,   0,  9,   0,  8,   0, 0, 0);
    cyc(1, 0, 1, UP, WR, 0,   4,  9,   0,  2,   1, 1, 0);
    cyc(1, 1, 0, UP, WR, 8,   0,  9,   0,  8,   0, 1, 0);
    cyc(1, 0, 1, UP, WR, 0,   4,  9,   1,  2,   1, 1, 0);
    cyc(1, 0, 1, UP, WR, 0,   0,  9,   0,  2,   0, 1, 0);
    cyc(1, 0, 0, UP, WR, 0,   0,  9,   1,  2,   0, 0, 0);
    // limit 0: counter pinned at 0, back-to-back events keep wrap_p high.
    cyc(1, 1, 0, DN, WR, 5,   0,  0,   0,  0,   0, 0, 0);
    cyc(1, 0, 1, DN, WR, 0,   2,  0,   0,  0,   1, 0, 1);
    cyc(1, 0, 1, UP, SA, 0,   1,  0,   0,  0,   1, 1, 1);
    // Wrap down with step > limit+1 lands on 0; saturate down stops at 0.
    cyc(1, 1, 0, DN, WR, 2,   0,  9,   1,  2,   0, 0, 0);
    cyc(1, 0, 1, DN, WR, 0,  15,  9,   0,  0,   1, 0, 1);
    cyc(1, 1, 0, DN, SA, 3,   0,  9,   1,  3,   0, 0, 0);
    cyc(1, 0, 1, DN, SA, 0,   5,  9,   0,  0,   1, 0, 1);
    cyc(1, 0, 0, DN, SA, 0,   0,  9,   0,  0,   0, 0, 1);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    check("drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
